// File: rtl/phase_timer_pkg.sv
// Shared types and elaboration helpers for the phase timer and its tick prescaler.
package phase_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int calc_div(input int clk_freq, input int tick_hz);
        return clk_freq / tick_hz;
    endfunction

    function automatic int presc_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 divider; tick flags the cycle in which the count wraps,
// so the owner can register its update on that same edge.
module tick_prescaler
    import phase_timer_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = presc_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + PW'(1);
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Game-phase timer: prescaled phase counter with start/pause/clear, saturate or wrap.
// Optional down-counting (count_down input) is enabled by defining PHASE_TIMER_DOWN_EN.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int CLK_FREQ = 26_000_000,
    parameter int TICK_HZ  = 1,
    parameter int WIDTH    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             start,
    input  logic             pause,
    input  logic             wrap_mode,
    input  logic [WIDTH-1:0] limit,
`ifdef PHASE_TIMER_DOWN_EN
    input  logic             count_down,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             wrap,
    output logic             busy
);

    localparam int DIV = calc_div(CLK_FREQ, TICK_HZ);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("phase_timer: CLK_FREQ/TICK_HZ must be at least 2");
        end
    endgenerate

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic             tick_q;
    logic             done_q;
    logic             wrap_q;
    logic             busy_q;
    logic             down_q;
    logic             start_down;

`ifdef PHASE_TIMER_DOWN_EN
    assign start_down = count_down;
`else
    assign start_down = 1'b0;
    assign down_q     = 1'b0;
`endif

    logic             is_busy;
    logic             can_start;
    logic             presc_clr;
    logic             presc_en;
    logic             presc_term;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] stepped;
    logic             at_target;

    assign is_busy   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign can_start = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign presc_clr = clear || (start && can_start);
    // Leaving PAUSE advances the prescaler on that same edge, so the pause costs exactly its length.
    assign presc_en  = is_busy && !pause && !clear;

    assign target    = down_q ? '0 : limit_q;
    assign reload    = down_q ? limit_q : '0;
    assign stepped   = down_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
    assign at_target = (count_q == target);

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (presc_clr),
        .en      (presc_en),
        .tick    (presc_term)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PHASE_TIMER_DOWN_EN
            down_q  <= 1'b0;
`endif
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            if (clear) begin
                state_q <= ST_IDLE;
                count_q <= '0;
                busy_q  <= 1'b0;
            end else if (start && can_start) begin
                limit_q <= limit;
                mode_q  <= wrap_mode;
`ifdef PHASE_TIMER_DOWN_EN
                down_q  <= count_down;
`endif
                count_q <= start_down ? limit : '0;
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
            end else if (is_busy) begin
                if (pause) begin
                    state_q <= ST_PAUSE;
                end else if (!mode_q && at_target) begin
                    // Only reachable with a zero-length phase: finish without ever ticking.
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= ST_RUN;
                    if (presc_term) begin
                        tick_q <= 1'b1;
                        if (mode_q) begin
                            if (at_target) begin
                                count_q <= reload;
                                wrap_q  <= 1'b1;
                            end else begin
                                count_q <= stepped;
                            end
                        end else begin
                            count_q <= stepped;
                            if (stepped == target) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign done  = done_q;
    assign wrap  = wrap_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer (DIV=10, WIDTH=2): tick-number model checked every cycle
// plus hand-computed literal checkpoints.
module tb_phase_timer;

    localparam int DIV = 10;
    localparam int W   = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         wrap_mode = 1'b0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] count;
    logic         tick;
    logic         done;
    logic         wrap;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phase_timer #(
        .CLK_FREQ (10),
        .TICK_HZ  (1),
        .WIDTH    (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .start     (start),
        .pause     (pause),
        .wrap_mode (wrap_mode),
        .limit     (limit),
`ifdef PHASE_TIMER_DOWN_EN
        .count_down(1'b0),
`endif
        .count     (count),
        .tick      (tick),
        .done      (done),
        .wrap      (wrap),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a phase is a count of unfrozen busy cycles; the count is derived from the tick number.
    initial begin : model
        bit m_active;
        bit m_mode;
        int m_lim;
        int m_el;
        int m_cnt;
        int n;
        bit e_tick;
        bit e_done;
        bit e_wrap;
        bit s_clear;
        bit s_start;
        bit s_pause;
        bit s_wm;
        int s_lim;
        m_active = 0; m_mode = 0; m_lim = 0; m_el = 0; m_cnt = 0;
        @(posedge clk);
        forever begin
            @(posedge clk or negedge reset_n);
            e_tick = 0; e_done = 0; e_wrap = 0;
            if (!reset_n) begin
                m_active = 0; m_mode = 0; m_lim = 0; m_el = 0; m_cnt = 0;
            end else begin
                s_clear = clear; s_start = start; s_pause = pause;
                s_wm = wrap_mode; s_lim = int'(limit);
                if (s_clear) begin
                    m_active = 0; m_cnt = 0;
                end else if (s_start && !m_active) begin
                    m_active = 1; m_lim = s_lim; m_mode = s_wm; m_cnt = 0; m_el = 0;
                end else if (m_active && !s_pause) begin
                    m_el++;
                    if (!m_mode && m_lim == 0) begin
                        e_done = 1; m_active = 0;
                    end else if (m_el % DIV == 0) begin
                        n = m_el / DIV;
                        e_tick = 1;
                        if (m_mode) begin
                            m_cnt  = n % (m_lim + 1);
                            e_wrap = (m_cnt == 0);
                        end else begin
                            m_cnt = n;
                            if (n == m_lim) begin
                                e_done = 1; m_active = 0;
                            end
                        end
                    end
                end
            end
            #1;
            check("model count", 32'(count), 32'(m_cnt));
            check("model tick", 32'(tick), 32'(e_tick));
            check("model done", 32'(done), 32'(e_done));
            check("model wrap", 32'(wrap), 32'(e_wrap));
            check("model busy", 32'(busy), 32'(m_active));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int lim, input bit wm);
        limit = W'(lim);
        wrap_mode = wm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        limit = ~W'(lim);
        wrap_mode = ~wm;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin : stim
        cyc(3);
        reset_n = 1'b1;
        cyc(2);
        check("reset count", 32'(count), 0);
        check("reset busy", 32'(busy), 0);
        check("reset tick", 32'(tick), 0);
        check("reset done", 32'(done), 0);
        check("reset wrap", 32'(wrap), 0);

        do_start(2, 1'b0);
        check("sat busy+0", 32'(busy), 1);
        cyc(9);
        check("sat tick+9", 32'(tick), 0);
        check("sat count+9", 32'(count), 0);
        cyc(1);
        check("sat tick+10", 32'(tick), 1);
        check("sat count+10", 32'(count), 1);
        cyc(10);
        check("sat count+20", 32'(count), 2);
        check("sat done+20", 32'(done), 1);
        check("sat tick+20", 32'(tick), 1);
        check("sat busy+20", 32'(busy), 0);
        cyc(100);
        check("sat count+120", 32'(count), 2);
        check("sat done+120", 32'(done), 0);

        do_start(2, 1'b1);
        cyc(30);
        check("wrap count+30", 32'(count), 0);
        check("wrap pulse+30", 32'(wrap), 1);
        cyc(10);
        check("wrap count+40", 32'(count), 1);
        check("wrap pulse+40", 32'(wrap), 0);
        do_clear();
        cyc(2);

        do_start(3, 1'b0);
        cyc(4);
        pause = 1'b1;
        cyc(16);
        check("pause busy", 32'(busy), 1);
        check("pause count", 32'(count), 0);
        cyc(9);
        pause = 1'b0;
        cyc(5);
        check("pause tick+34", 32'(tick), 0);
        cyc(1);
        check("pause tick+35", 32'(tick), 1);
        check("pause count+35", 32'(count), 1);

        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        check("clr count", 32'(count), 0);
        check("clr busy", 32'(busy), 0);
        cyc(1);
        check("clr start ignored", 32'(busy), 0);

        do_start(0, 1'b0);
        check("lim0 busy+0", 32'(busy), 1);
        check("lim0 done+0", 32'(done), 0);
        cyc(1);
        check("lim0 done+1", 32'(done), 1);
        check("lim0 tick+1", 32'(tick), 0);
        check("lim0 busy+1", 32'(busy), 0);
        cyc(20);

        do_start(3, 1'b1);
        cyc(30);
        check("lim3 count+30", 32'(count), 3);
        cyc(10);
        check("lim3 count+40", 32'(count), 0);
        check("lim3 wrap+40", 32'(wrap), 1);
        do_clear();
        cyc(2);

        do_start(3, 1'b0);
        cyc(20);
        check("rst pre count", 32'(count), 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst async count", 32'(count), 0);
        check("rst async busy", 32'(busy), 0);
        check("rst async tick", 32'(tick), 0);
        check("rst async done", 32'(done), 0);
        check("rst async wrap", 32'(wrap), 0);
        #1;
        reset_n = 1'b1;
        cyc(5);
        check("rst idle busy", 32'(busy), 0);
        check("rst idle count", 32'(count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
- Parametrised game-phase timer: on-chip tick prescaler plus WIDTH-bit phase counter with programmable terminal value.
- Adds start/pause/clear control, saturate-or-wrap mode, and tick/done/wrap strobes.
- Drives round timing (mole pop-up windows, round length) for the game controller.
- Successor to the fixed 2-bit saturating 1 Hz phase counter.

Parameters:
- CLK_FREQ, 26_000_000: input clock frequency in Hz.
- TICK_HZ, 1: counter step rate in Hz. DIV = CLK_FREQ/TICK_HZ, which must be at least 2 (elaboration error otherwise).
- WIDTH, 2: phase counter and limit width in bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear to IDLE.
- start  in  1  begin counting from the phase origin.
- pause  in  1  level: freeze counter and prescaler while high.
- wrap_mode  in  1  0 = saturate at limit; 1 = roll over to origin. Sampled at start.
- limit  in  WIDTH  terminal count. Sampled at start.
- count  out  WIDTH  current phase value.
- tick  out  1  one-cycle pulse per prescaler period while counting.
- done  out  1  one-cycle pulse when saturating at limit.
- wrap  out  1  one-cycle pulse on rollover.
- busy  out  1  high in RUN or PAUSE.

Behaviour:
- reset_n low (asynchronous): state=IDLE; count, prescaler, limit_q, mode_q, tick, done, wrap and busy all 0.
- All outputs are registered.
- States:
  - IDLE: count=0.
  - RUN: prescaler advances.
  - PAUSE: prescaler and count hold.
  - DONE: count holds at limit_q.
- Priority per cycle: clear > start > pause > tick.
- clear (any state): next cycle state=IDLE, count=0, prescaler=0, strobes 0.
- start in IDLE or DONE: latch limit_q=limit and mode_q=wrap_mode; count=0; prescaler=0; state=RUN.
- start in RUN or PAUSE: ignored.
- Changes to limit or wrap_mode while busy: ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN.
  - At DIV-1 it returns to 0 and the tick strobe fires the following cycle, coincident with the count update.
  - First tick occurs exactly DIV cycles after the start cycle.
- RUN with pause=1: state=PAUSE, prescaler value retained. PAUSE with pause=0: back to RUN, prescaler resumes from the held value.
- Pause and start together in IDLE: start wins, enters RUN. If pause is still high next cycle, state goes to PAUSE.
- Saturate (mode_q=0):
  - On each tick, count+1.
  - When the new count equals limit_q: state=DONE, done pulses with that update, no further ticks.
  - limit_q=0: done pulses one cycle after start, tick stays 0.
- Wrap (mode_q=1):
  - On a tick with count==limit_q: count=0, wrap pulses, state stays RUN.
  - Otherwise count+1.
  - limit_q=0: count stays 0, wrap pulses on every tick.
  - done never asserts.
- Arithmetic: unsigned modulo 2^WIDTH. limit = 2^WIDTH-1 is legal with no overflow.
- Reset asserted mid-count: immediate return to reset values. No pulse is emitted on release.

Optional Feature:
- PHASE_TIMER_DOWN_EN defined:
  - Adds input count_down (1 bit), sampled at start.
  - When count_down=1: count loads limit_q, decrements on each tick, done at 0 (saturate), and reloads limit_q with a wrap pulse at 0 (wrap mode).
- Undefined: port absent, up-count only, behaviour exactly as above.

Decomposition:
- Package phase_timer_pkg:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - Function computing DIV and prescaler width ($clog2(DIV)).
- Sub-module tick_prescaler: parameter DIV; inputs clk, reset_n, clr, en; output tick.
- phase_timer: FSM plus counter.

Test Plan (bench uses CLK_FREQ=10, TICK_HZ=1, so DIV=10; WIDTH=2):
- Saturate: limit=2, wrap_mode=0, start pulse → tick at +10 and +20 cycles, count 1 then 2, done pulse at +20, busy falls. No further change after 100 cycles.
- Wrap: limit=2, wrap_mode=1 → count sequence 0,1,2,0,1 at 10-cycle spacing, wrap pulse at +30, done never asserts.
- Pause: pause high for 25 cycles starting at +5 after start → first tick at +35, count holds during pause, busy stays 1.
- Clear mid-run at count=1, with clear and start asserted together → next cycle state IDLE, count 0, busy 0. The start is ignored.
- Edge limits:
  - limit=0, saturate → done one cycle after start, no tick.
  - limit=3 with wrap → count 3→0 with a wrap pulse.
- Async reset: reset_n pulsed low between clock edges while count=2 → all outputs 0 immediately. After release, stays in IDLE.
